// File: rtl/request_grant_sequencer_pkg.sv
// Shared codings for the request/grant sequencer: width defaults and the one-hot helper.
package request_grant_sequencer_pkg;
  localparam int DEF_INPUT_WIDTH  = 8;
  localparam int DEF_OUTPUT_WIDTH = $clog2(DEF_INPUT_WIDTH);

  // Bit `pos` of the one-hot vector that encodes index `idx`.
  function automatic logic onehot_bit(input int idx, input int pos);
    return idx == pos;
  endfunction
endpackage

// File: rtl/request_priority_pick.sv
// Combinational picker: first set bit of vector_i searching downward from start_i, wrapping.
module request_priority_pick
  import request_grant_sequencer_pkg::*;
#(
  parameter int W  = DEF_INPUT_WIDTH,
  parameter int OW = $clog2(W)
) (
  input  logic [W-1:0]  vector_i,
  input  logic [OW-1:0] start_i,
  output logic [OW-1:0] index_o,
  output logic          found_o
);
  int p;

  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    p       = 0;
    for (int k = 0; k < W; k++) begin
      p = (int'(start_i) - k + W) % W;
      if (!found_o && vector_i[p]) begin
        found_o = 1'b1;
        index_o = p[OW-1:0];
      end
    end
  end
endmodule

// File: rtl/request_grant_sequencer.sv
// Captures request pulses into a pending set and issues one registered grant at a time.
// Define RR_FAIR_EN for round-robin selection; default is fixed MSB-first priority.
module request_grant_sequencer
  import request_grant_sequencer_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  request,
  output logic [OUTPUT_WIDTH-1:0] grant_index,
  output logic                    grant_valid,
  input  logic                    grant_ready,
  output logic [INPUT_WIDTH-1:0]  pending,
  output logic                    busy
);
  logic [INPUT_WIDTH-1:0]  pend_q, pend_d, eff, clr_mask;
  logic [OUTPUT_WIDTH-1:0] gi_q, gi_d, start, pick_idx;
  logic                    gv_q, gv_d, pick_found, slot_free;

`ifdef RR_FAIR_EN
  logic [OUTPUT_WIDTH-1:0] last_q, last_d;
  // Search begins one below the last loaded line; last=0 wraps to the top line.
  assign start = (last_q == '0) ? OUTPUT_WIDTH'(INPUT_WIDTH-1) : last_q - OUTPUT_WIDTH'(1);
`else
  assign start = OUTPUT_WIDTH'(INPUT_WIDTH-1);
`endif

  assign eff       = pend_q | request;
  assign slot_free = !gv_q || grant_ready;

  request_priority_pick #(.W(INPUT_WIDTH), .OW(OUTPUT_WIDTH)) u_pick (
    .vector_i (eff),
    .start_i  (start),
    .index_o  (pick_idx),
    .found_o  (pick_found)
  );

  for (genvar i = 0; i < INPUT_WIDTH; i++) begin : g_mask
    assign clr_mask[i] = onehot_bit(int'(pick_idx), i);
  end

  always_comb begin
    gi_d   = gi_q;
    gv_d   = gv_q;
    pend_d = eff;
`ifdef RR_FAIR_EN
    last_d = last_q;
`endif
    if (slot_free) begin
      if (pick_found) begin
        gi_d   = pick_idx;
        gv_d   = 1'b1;
        pend_d = eff & ~clr_mask;
`ifdef RR_FAIR_EN
        last_d = pick_idx;
`endif
      end else begin
        gv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gi_q   <= '0;
      gv_q   <= 1'b0;
      pend_q <= '0;
`ifdef RR_FAIR_EN
      last_q <= '0;
`endif
    end else begin
      gi_q   <= gi_d;
      gv_q   <= gv_d;
      pend_q <= pend_d;
`ifdef RR_FAIR_EN
      last_q <= last_d;
`endif
    end
  end

  assign grant_index = gi_q;
  assign grant_valid = gv_q;
  assign pending     = pend_q;
  assign busy        = gv_q | (|pend_q);
endmodule
